// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the control unit (master) and the program-counter
// sequencer (slave).
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              halt;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_off;
  logic              call_en;
  logic              ret_en;
  logic [ADDR_W-1:0] pc;
  logic              halted;
  logic              stack_empty;
  logic              stack_full;
  logic              stack_ovf;
  logic              stack_unf;

  modport master (
    output halt, jump_en, jump_addr, branch_en, branch_off, call_en, ret_en,
    input  pc, halted, stack_empty, stack_full, stack_ovf, stack_unf
  );

  modport slave (
    input  halt, jump_en, jump_addr, branch_en, branch_off, call_en, ret_en,
    output pc, halted, stack_empty, stack_full, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter with a LIFO return-address stack; one action per cycle chosen by
// fixed priority halt > ret > call > jump > branch > increment.
module pc_sequencer #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, top;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              halted_q;
  logic              push;
  logic              full, empty;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  assign pc_inc = pc_q + ADDR_W'(1);
  assign full   = (cnt_q == CntW'(STACK_DEPTH));
  assign empty  = (cnt_q == '0);

  // Only the entry just below the count is ever read.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (cnt_q == CntW'(i + 1)) top = stack_q[i];
    end
  end

  always_comb begin
    pc_d  = pc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    if (bus.halt) begin
      pc_d = pc_q;
    end else if (bus.ret_en) begin
      if (!empty) begin
        pc_d  = top;
        cnt_d = cnt_q - CntW'(1);
      end else begin
        pc_d  = pc_inc;
        unf_d = 1'b1;
      end
    end else if (bus.call_en) begin
      if (!full) begin
        push  = 1'b1;
        pc_d  = bus.jump_addr;
        cnt_d = cnt_q + CntW'(1);
      end else begin
        pc_d  = pc_inc;
        ovf_d = 1'b1;
      end
    end else if (bus.jump_en) begin
      pc_d = bus.jump_addr;
    end else if (bus.branch_en) begin
      pc_d = pc_q + bus.branch_off;
    end else begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_VEC;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      halted_q <= bus.halt;
    end
  end

  // Stack contents need no reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (push && cnt_q == CntW'(i)) stack_q[i] <= pc_inc;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.stack_ovf   = ovf_q;
  assign bus.stack_unf   = unf_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program counter with a hardware call/return stack, the next-generation instruction-address source for the CPU core. It produces the fetch address each cycle. It supports halt, absolute jump, PC-relative branch, subroutine call and return, and a configurable reset vector. It sits between the control unit, which drives the request strobes, and instruction memory, which consumes `pc`.

## Interface
- `ADDR_W`, 8, width of the program address; all address arithmetic is modulo 2^ADDR_W.
- `STACK_DEPTH`, 4, number of return-address entries; legal range 1–16.
- `RESET_VEC`, 0, value loaded into `pc` on reset.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `halt`  in  1  freezes `pc` and the stack while high.
- `jump_en`  in  1  absolute jump request.
- `jump_addr`  in  ADDR_W  jump target.
- `branch_en`  in  1  relative branch request.
- `branch_off`  in  ADDR_W  two's-complement branch offset.
- `call_en`  in  1  subroutine call request; target is `jump_addr`.
- `ret_en`  in  1  return request.
- `pc`  out  ADDR_W  current fetch address.
- `halted`  out  1  registered copy of `halt`.
- `stack_empty`  out  1  stack holds 0 entries.
- `stack_full`  out  1  stack holds STACK_DEPTH entries.
- `stack_ovf`  out  1  sticky; a call was attempted while full.
- `stack_unf`  out  1  sticky; a return was attempted while empty.

## Operation
- Reset values: `pc`=RESET_VEC; stack count=0; `stack_empty`=1; `stack_full`=0; `stack_ovf`=0; `stack_unf`=0; `halted`=0. Stack contents are don't-care.
- Each cycle performs exactly one action, chosen by fixed priority: rst > halt > ret_en > call_en > jump_en > branch_en > increment. Lower-priority requests asserted in the same cycle are dropped, not queued.
- Increment: `pc` <= `pc`+1. From 2^ADDR_W−1 it wraps to 0.
- Halt: `pc`, stack and count hold their values. The sticky flags hold.
- Return with count>0: `pc` <= top entry; count decrements.
- Return with count=0: `pc` <= `pc`+1; `stack_unf` sets; count stays 0.
- Call with count<STACK_DEPTH: push (`pc`+1, wrapped) onto the stack; `pc` <= `jump_addr`; count increments.
- Call with count=STACK_DEPTH: no push; `pc` <= `pc`+1; `stack_ovf` sets; existing entries are unchanged.
- Jump: `pc` <= `jump_addr`.
- Branch: `pc` <= `pc` + `branch_off`, modulo 2^ADDR_W. A negative offset moves backwards; offset 0 is a self-loop.
- Stack implementation: LIFO in a register array indexed by count. Only the top entry is readable.
- `stack_empty` and `stack_full` are decoded from the registered count, so they are valid in the same cycle as the count.
- `stack_ovf` and `stack_unf` clear only on `rst`.
- `halted` <= `halt` every cycle; it is 0 during reset.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Latency is one cycle: a control sampled at edge N is visible on `pc` after edge N.
- Requests are single-cycle strobes with no handshake. A strobe held high for k cycles performs its action k times, subject to priority.
- Back-to-back call/return is supported at one operation per cycle: a return in the cycle after a call pops the address just pushed.
- `rst` asserted mid-operation, including while `halt` is high or the stack is non-empty, takes effect at the next edge. It discards the stack and clears both sticky flags.
- Deasserting `halt` resumes execution from the held `pc` at the next edge; no cycle is skipped.

## Test plan
- Reset, then 260 free-running cycles with ADDR_W=8 → `pc` runs 0..255, wraps to 0, and reads 4 at cycle 260. Repeat with RESET_VEC=0x10 → `pc` starts at 0x10.
- At `pc`=0x20, assert `branch_off`=0xFC (−4) for one cycle → `pc`=0x1C. Then `jump_en` with `jump_addr`=0x80 → `pc`=0x80. Then `halt` for 3 cycles → `pc` stays 0x80, `halted`=1; after release → 0x81.
- Nested calls with depth 4: calls from 0x05, 0x40, 0x50, 0x60 → stack holds 06,41,51,61 and `stack_full`=1. Four returns → `pc` sequence 61,51,41,06, then `stack_empty`=1.
- Fifth call while full → `stack_ovf`=1, `pc` increments, no push. A return on the empty stack → `stack_unf`=1, `pc` increments. Both flags stay set until `rst`.
- In one cycle assert `ret_en`, `call_en`, `jump_en` and `branch_en` with the stack non-empty → only the return occurs. In one cycle assert `halt` with `ret_en` → nothing changes.
- Assert `rst` while halted with 3 stack entries and `stack_ovf`=1 → next cycle `pc`=RESET_VEC, `stack_empty`=1, both sticky flags 0, `halted`=0.
